psum_accum_ctrl: RTL and testbench
==================================

PSUM_ACCUM_CTRL -- requirements
Module: psum_accum_ctrl

Interface
REQ-001 Parameter ADDR_PSUM, default 12, SHALL set the PSUM row memory address width.
REQ-002 Parameter PSUM_BW, default 32, SHALL set the partial-sum data width.
REQ-003 Ports SHALL be, clock and reset first: clk  in  1  single clock, all logic on rising edge; reset  in  1  synchronous, active-high reset.
REQ-004 Ports: start  in  1  pass start pulse; first_pass  in  1  overwrite mode, sampled at start; pass_last  in  1  drain after this pass, sampled at start; drain_len  in  ADDR_PSUM+1  entries to drain, sampled at start; pass_end  in  1  pulse, no further psums this pass.
REQ-005 Ports: in_valid  in  1  incoming psum beat; in_addr  in  ADDR_PSUM  target entry; in_data  in  PSUM_BW  signed psum.
REQ-006 Ports: mem_ena, mem_wea  out  1 each  write port strobes; mem_addra  out  ADDR_PSUM; mem_dina  out  PSUM_BW; mem_enb  out  1  read enable; mem_addrb  out  ADDR_PSUM; mem_doutb  in  PSUM_BW  read data, valid one cycle after mem_enb.
REQ-007 Ports: out_valid  out  1; out_ready  in  1; out_data  out  PSUM_BW; out_last  out  1  final drained word; busy  out  1  state not IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-008 FSM SHALL have states IDLE, ACCUM, FLUSH, DRAIN, DONE.
REQ-009 IDLE->ACCUM on start; start in any other state SHALL be ignored.
REQ-010 ACCUM->FLUSH on pass_end; a beat with in_valid in the same cycle as pass_end SHALL still be accepted.
REQ-011 FLUSH SHALL wait until the pipeline holds no beat, then go to DRAIN if pass_last was sampled 1 and drain_len is nonzero, else to DONE.
REQ-012 DRAIN->DONE when the out_last word is accepted (out_valid and out_ready); DONE->IDLE after exactly one cycle, with done=1 only in DONE.
REQ-013 in_valid SHALL be ignored outside ACCUM, with no memory access.
REQ-014 Accumulate stage S0: in ACCUM with in_valid=1, drive mem_enb=1 and mem_addrb=in_addr combinationally, and register addr, data and valid into S1.
REQ-015 Accumulate stage S1: compute sum = operand + s1_data modulo 2^PSUM_BW, with no saturation.
REQ-016 The S1 operand SHALL be 0 if first_pass was sampled 1, else the forwarded value if the forward flag is set, else mem_doutb.
REQ-017 S1 SHALL drive mem_ena=mem_wea=1, mem_addra=s1_addr, mem_dina=sum; the write lands one cycle after the beat's in_valid.
REQ-018 Hazard rule: if the S0 address equals the valid S1 address in the same cycle, set the forward flag and register sum; S1 then uses that registered sum instead of mem_doutb, because the memory returns the old value on a same-cycle read/write collision.
REQ-019 Beats two or more cycles apart SHALL need no forwarding; sustained throughput SHALL be one beat per cycle with no backpressure on in_valid.
REQ-020 Drain SHALL read addresses 0 to drain_len-1 in order through port b into a 2-entry output FIFO.
REQ-021 Drain SHALL issue a read only when FIFO count plus in-flight reads minus the current-cycle pop is less than 2.
REQ-022 Drain output: out_data/out_valid come from the FIFO head; out_last=1 only with the word at drain_len-1.
REQ-023 With out_ready held 1, drain SHALL deliver one word per cycle, with the first out_valid 2 cycles after entering DRAIN.
REQ-024 With out_ready=0, out_data SHALL be held stable, no word SHALL be lost, and no more than 2 reads SHALL be outstanding.
REQ-025 The write port SHALL be idle (mem_ena=0) in DRAIN.
REQ-026 Drain SHALL NOT modify memory; clearing between tiles is done through first_pass.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE and clear the S1 stage, forward flag, FIFO and in-flight count.
REQ-028 During reset, all outputs SHALL be 0 (mem_* strobes, out_valid, out_last, busy, done, data/address buses).
REQ-029 Reset mid-operation SHALL abandon in-flight beats with no write and leave memory contents unchanged; reset SHALL dominate start.

Verification
REQ-030 Overwrite: start with first_pass=1, pass_last=0; beat addr 5 data 7; pass_end -> write addr 5 value 7 one cycle after the beat; done pulses once.
REQ-031 Accumulate: memory[5]=7, first_pass=0; beats addr 5 data -3 and addr 9 data 4 on consecutive cycles -> writes 4 to addr 5 and mem[9]+4 to addr 9.
REQ-032 Forwarding: first_pass=0, mem[3]=10; three back-to-back beats addr 3 data 1, 2, 3 -> writes 11, 13, 16 in successive cycles.
REQ-033 Wrap: mem[0]=0x7FFFFFFF, beat data 1 -> write 0x80000000.
REQ-034 Drain backpressure: drain_len=4, mem[0..3]=1,2,3,4, out_ready toggling 1,0,0,1,... -> output sequence 1,2,3,4, out_last only on value 4, data stable while stalled, then done.
REQ-035 Reset mid-DRAIN after 2 words: next cycle out_valid=0 and busy=0; a new start operates normally.

Source files
------------

// File: rtl/psum_accum_ctrl.sv
// Partial-sum accumulate controller: two-stage read-modify-write into a PSUM row
// memory with same-address forwarding, followed by an optional in-order drain through a 2-entry FIFO.
module psum_accum_ctrl #(
  parameter int ADDR_PSUM = 12,
  parameter int PSUM_BW   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 first_pass,
  input  logic                 pass_last,
  input  logic [ADDR_PSUM:0]   drain_len,
  input  logic                 pass_end,
  input  logic                 in_valid,
  input  logic [ADDR_PSUM-1:0] in_addr,
  input  logic [PSUM_BW-1:0]   in_data,
  output logic                 mem_ena,
  output logic                 mem_wea,
  output logic [ADDR_PSUM-1:0] mem_addra,
  output logic [PSUM_BW-1:0]   mem_dina,
  output logic                 mem_enb,
  output logic [ADDR_PSUM-1:0] mem_addrb,
  input  logic [PSUM_BW-1:0]   mem_doutb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PSUM_BW-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, DRAIN, DONE} state_t;

  state_t               r_state, w_next;
  logic                 r_first_pass, r_pass_last;
  logic [ADDR_PSUM:0]   r_drain_len;

  logic                 r_s1_valid, r_fwd;
  logic [ADDR_PSUM-1:0] r_s1_addr;
  logic [PSUM_BW-1:0]   r_s1_data, r_fwd_data;

  logic [ADDR_PSUM:0]   r_rd_addr;
  logic                 r_inflight, r_inf_last;
  logic [PSUM_BW-1:0]   r_fifo_data [2];
  logic                 r_fifo_last [2];
  logic                 r_wr_ptr, r_rd_ptr;
  logic [1:0]           r_count;

  logic                 w_accum, w_drain, w_busy, w_done;
  logic                 w_s0_fire, w_rd_issue, w_fifo_valid, w_pop, w_head_last;
  logic [2:0]           w_occ;
  logic [ADDR_PSUM:0]   w_rd_next;
  logic [PSUM_BW-1:0]   w_operand, w_sum, w_head_data;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next  = r_state;
    w_accum = 1'b0;
    w_drain = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = ACCUM;
      end
      ACCUM: begin
        w_accum = 1'b1;
        if (pass_end) w_next = FLUSH;
      end
      FLUSH: begin
        if (!r_s1_valid)
          w_next = (r_pass_last && (r_drain_len != '0)) ? DRAIN : DONE;
      end
      DRAIN: begin
        w_drain = 1'b1;
        if (w_pop && w_head_last) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Accumulate datapath: S0 issues the read, S1 adds and writes back.
  assign w_s0_fire = w_accum && in_valid;
  assign w_operand = r_first_pass ? '0 : (r_fwd ? r_fwd_data : mem_doutb);
  assign w_sum     = w_operand + r_s1_data;

  // Drain datapath: reads are throttled so FIFO entries plus in-flight reads never exceed two.
  assign w_fifo_valid = w_drain && (r_count != 2'd0);
  assign w_pop        = w_fifo_valid && out_ready;
  assign w_head_data  = r_fifo_data[r_rd_ptr];
  assign w_head_last  = r_fifo_last[r_rd_ptr];
  assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_issue   = w_drain && (r_rd_addr < r_drain_len) && (w_occ < 3'd2);
  assign w_rd_next    = r_rd_addr + {{ADDR_PSUM{1'b0}}, 1'b1};

  // Outputs are forced low while reset is asserted, independent of register state.
  assign mem_enb   = !reset && (w_s0_fire || w_rd_issue);
  assign mem_addrb = !mem_enb ? '0 : (w_s0_fire ? in_addr : r_rd_addr[ADDR_PSUM-1:0]);
  assign mem_ena   = !reset && r_s1_valid;
  assign mem_wea   = mem_ena;
  assign mem_addra = mem_ena ? r_s1_addr : '0;
  assign mem_dina  = mem_ena ? w_sum : '0;
  assign out_valid = !reset && w_fifo_valid;
  assign out_data  = out_valid ? w_head_data : '0;
  assign out_last  = out_valid && w_head_last;
  assign busy      = !reset && w_busy;
  assign done      = !reset && w_done;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_first_pass <= 1'b0;
      r_pass_last  <= 1'b0;
      r_drain_len  <= '0;
      r_s1_valid   <= 1'b0;
      r_fwd        <= 1'b0;
      r_rd_addr    <= '0;
      r_inflight   <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      r_state    <= w_next;
      r_s1_valid <= w_s0_fire;
      r_fwd      <= w_s0_fire && r_s1_valid && (in_addr == r_s1_addr);
      if (r_state == IDLE && start) begin
        r_first_pass <= first_pass;
        r_pass_last  <= pass_last;
        r_drain_len  <= drain_len;
        r_rd_addr    <= '0;
      end else if (w_rd_issue) begin
        r_rd_addr <= w_rd_next;
      end
      r_inflight <= w_rd_issue;
      r_wr_ptr   <= r_wr_ptr ^ r_inflight;
      r_rd_ptr   <= r_rd_ptr ^ w_pop;
      r_count    <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // NOTE: payload registers and FIFO storage are left unreset; their valid/count qualifiers are reset.
  always_ff @(posedge clk) begin
    r_s1_addr  <= in_addr;
    r_s1_data  <= in_data;
    r_fwd_data <= w_sum;
    if (w_rd_issue) r_inf_last <= (w_rd_next == r_drain_len);
    if (r_inflight) begin
      r_fifo_data[r_wr_ptr] <= mem_doutb;
      r_fifo_last[r_wr_ptr] <= r_inf_last;
    end
  end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed bench for psum_accum_ctrl: hand-computed vectors against a behavioral
// read-first dual-port PSUM memory (write on port a, registered read on port b).
module tb_psum_accum_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, start, first_pass, pass_last, pass_end, in_valid, out_ready;
  logic [AW:0]   drain_len;
  logic [AW-1:0] in_addr, mem_addra, mem_addrb;
  logic [DW-1:0] in_data, mem_dina, mem_doutb, out_data;
  logic          mem_ena, mem_wea, mem_enb, out_valid, out_last, busy, done;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  psum_accum_ctrl #(.ADDR_PSUM(AW), .PSUM_BW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .first_pass(first_pass),
    .pass_last(pass_last), .drain_len(drain_len), .pass_end(pass_end),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
    .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // Read-first memory: a same-cycle read of the written address returns the old value.
  always @(posedge clk) begin
    if (mem_enb) mem_doutb <= mem[mem_addrb];
    if (mem_ena && mem_wea) mem[mem_addra] <= mem_dina;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Starts a pass from IDLE; returns at the falling edge of the first ACCUM cycle.
  task automatic start_pass(input logic fp, input logic pl, input logic [AW:0] dl);
    start = 1'b1; first_pass = fp; pass_last = pl; drain_len = dl;
    @(negedge clk);
    start = 1'b0; first_pass = 1'b0; pass_last = 1'b0; drain_len = '0;
  endtask

  // Runs a bounded number of cycles after pass_end, checking one done pulse and return to idle.
  task automatic wait_done(input string tag, input int exp_ov);
    int nd, nov;
    nd = 0; nov = 0;
    in_valid = 1'b0; pass_end = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (done) nd++;
      if (out_valid) nov++;
      @(negedge clk);
    end
    check({tag, "_done_pulses"}, nd, 1);
    check({tag, "_out_valid_cycles"}, nov, exp_ov);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int k, nd;
    logic prev_stall;
    logic [DW-1:0] prev_data;

    reset = 1'b1; start = 1'b1; first_pass = 1'b1; pass_last = 1'b1; drain_len = 13'd4;
    pass_end = 1'b0; in_valid = 1'b1; in_addr = 12'd5; in_data = 32'd1; out_ready = 1'b1;

    // Reset state: outputs low even with start and in_valid asserted.
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_ena", mem_ena, 0);
    check("rst_mem_enb", mem_enb, 0);
    check("rst_mem_addrb", mem_addrb, 0);
    check("rst_mem_dina", mem_dina, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; first_pass = 1'b0; pass_last = 1'b0; drain_len = '0;
    in_valid = 1'b0;
    #1;
    check("post_rst_busy", busy, 0);
    @(negedge clk);

    // Overwrite pass: addr 5 <= 7.
    start_pass(1'b1, 1'b0, 13'd0);
    in_valid = 1'b1; in_addr = 12'd5; in_data = 32'd7;
    #1;
    check("ovr_busy", busy, 1);
    check("ovr_s0_enb", mem_enb, 1);
    check("ovr_s0_addrb", mem_addrb, 5);
    check("ovr_s0_no_write", mem_ena, 0);
    @(negedge clk);
    in_valid = 1'b0; pass_end = 1'b1;
    #1;
    check("ovr_wea", mem_wea, 1);
    check("ovr_addra", mem_addra, 5);
    check("ovr_dina", mem_dina, 7);
    @(negedge clk);
    wait_done("ovr", 0);
    check("ovr_mem5", mem[5], 7);

    // in_valid in IDLE causes no memory access.
    in_valid = 1'b1; in_addr = 12'd5; in_data = 32'd99;
    #1;
    check("idle_no_read", mem_enb, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("idle_no_write", mem_ena, 0);
    @(negedge clk);

    // Accumulate: mem[5]=7 plus -3, mem[9]=100 plus 4; second beat shares its cycle with pass_end.
    preload(12'd9, 32'd100);
    start_pass(1'b0, 1'b0, 13'd0);
    in_valid = 1'b1; in_addr = 12'd5; in_data = 32'hFFFF_FFFD;
    @(negedge clk);
    in_addr = 12'd9; in_data = 32'd4; pass_end = 1'b1;
    #1;
    check("acc_addra_5", mem_addra, 5);
    check("acc_dina_4", mem_dina, 4);
    @(negedge clk);
    in_valid = 1'b0; pass_end = 1'b0;
    #1;
    check("acc_addra_9", mem_addra, 9);
    check("acc_dina_104", mem_dina, 104);
    @(negedge clk);
    wait_done("acc", 0);
    check("acc_mem5", mem[5], 4);
    check("acc_mem9", mem[9], 104);

    // Forwarding: three back-to-back beats to addr 3; a start mid-pass must not resample first_pass.
    preload(12'd3, 32'd10);
    start_pass(1'b0, 1'b0, 13'd0);
    in_valid = 1'b1; in_addr = 12'd3; in_data = 32'd1;
    @(negedge clk);
    in_data = 32'd2; start = 1'b1; first_pass = 1'b1;
    #1;
    check("fwd_dina_11", mem_dina, 11);
    @(negedge clk);
    in_data = 32'd3; start = 1'b0; first_pass = 1'b0;
    #1;
    check("fwd_dina_13", mem_dina, 13);
    @(negedge clk);
    in_valid = 1'b0; pass_end = 1'b1;
    #1;
    check("fwd_addra_3", mem_addra, 3);
    check("fwd_dina_16", mem_dina, 16);
    @(negedge clk);
    wait_done("fwd", 0);
    check("fwd_mem3", mem[3], 16);

    // Wrap without saturation, then same-address beats two cycles apart (no forwarding needed).
    preload(12'd0, 32'h7FFF_FFFF);
    start_pass(1'b0, 1'b0, 13'd0);
    in_valid = 1'b1; in_addr = 12'd0; in_data = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("wrap_dina", mem_dina, 32'h8000_0000);
    @(negedge clk);
    in_valid = 1'b1; in_addr = 12'd3; in_data = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("gap_dina_20", mem_dina, 20);
    @(negedge clk);
    in_valid = 1'b1; in_addr = 12'd3; in_data = 32'd5;
    @(negedge clk);
    in_valid = 1'b0; pass_end = 1'b1;
    #1;
    check("gap_dina_25", mem_dina, 25);
    @(negedge clk);
    wait_done("gap", 0);

    // pass_last with drain_len=0 skips the drain.
    start_pass(1'b0, 1'b1, 13'd0);
    pass_end = 1'b1;
    @(negedge clk);
    wait_done("zero_drain", 0);

    // Drain with backpressure pattern 1,0,0,1.
    preload(12'd0, 32'd1);
    preload(12'd1, 32'd2);
    preload(12'd2, 32'd3);
    preload(12'd3, 32'd4);
    start_pass(1'b0, 1'b1, 13'd4);
    pass_end = 1'b1;
    @(negedge clk);
    pass_end = 1'b0;
    k = 0; nd = 0; prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i < 40; i++) begin
      out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      #1;
      if (busy) check("drn_write_idle", mem_ena, 0);
      if (out_valid) begin
        if (prev_stall) check("drn_hold", out_data, prev_data);
        if (out_ready) begin
          check("drn_data", out_data, 32'(k + 1));
          check("drn_last", out_last, (k == 3));
          k++;
        end
        prev_stall = !out_ready;
        prev_data  = out_data;
      end else begin
        prev_stall = 1'b0;
      end
      if (done) nd++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("drn_words", k, 4);
    check("drn_done_pulses", nd, 1);
    check("drn_idle", busy, 0);

    // Drain latency with out_ready=1, then reset after two words.
    start_pass(1'b0, 1'b1, 13'd4);
    pass_end = 1'b1;
    @(negedge clk);
    pass_end = 1'b0;
    #1;
    check("lat_flush_ov", out_valid, 0);
    @(negedge clk);
    #1;
    check("lat_d0_enb", mem_enb, 1);
    check("lat_d0_addrb", mem_addrb, 0);
    check("lat_d0_ov", out_valid, 0);
    @(negedge clk);
    #1;
    check("lat_d1_ov", out_valid, 0);
    check("lat_d1_addrb", mem_addrb, 1);
    @(negedge clk);
    #1;
    check("lat_d2_ov", out_valid, 1);
    check("lat_d2_data", out_data, 1);
    @(negedge clk);
    #1;
    check("lat_d3_data", out_data, 2);
    check("lat_d3_last", out_last, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_enb", mem_enb, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("after_rst_ov", out_valid, 0);
    check("after_rst_busy", busy, 0);

    // New pass after reset operates normally; drained rows are untouched.
    start_pass(1'b1, 1'b0, 13'd0);
    in_valid = 1'b1; in_addr = 12'd7; in_data = 32'h55;
    #1;
    check("new_enb", mem_enb, 1);
    @(negedge clk);
    in_valid = 1'b0; pass_end = 1'b1;
    #1;
    check("new_addra", mem_addra, 7);
    check("new_dina", mem_dina, 32'h55);
    @(negedge clk);
    wait_done("new", 0);
    check("keep_mem0", mem[0], 1);
    check("keep_mem1", mem[1], 2);
    check("keep_mem2", mem[2], 3);
    check("keep_mem3", mem[3], 4);
    check("new_mem7", mem[7], 32'h55);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
